// File: rtl/ball_engine.sv
// ball_engine: per-frame ball motion and collision stage for Pong.
// Moves the ball once per endofframe tick, bounces it off the top/bottom
// walls and both paddles, and reports hits, misses and motion to the
// game-control FSM. The FSM's restart level parks the ball at centre.
module ball_engine #(
  parameter int H_RES          = 640,
  parameter int V_RES          = 480,
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int LEFT_PADDLE_X  = 32,
  parameter int RIGHT_PADDLE_X = 600,
  parameter int SPEED          = 2,
  parameter int SERVE_DELAY    = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       endofframe,
  input  logic       restart,
  input  logic       serve,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [1:0] collided,
  output logic [1:0] missed,
  output logic       isMoving
);

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    MOVING   = 2'd1,
    RECENTER = 2'd2
  } state_t;

  // All geometry is evaluated in 10-bit unsigned arithmetic.
  localparam logic [9:0] CX     = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0] CY     = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [9:0] Y_MAX  = 10'(V_RES - BALL_SIZE);
  localparam logic [9:0] STEP   = 10'(SPEED);
  localparam logic [9:0] BSZ    = 10'(BALL_SIZE);
  localparam logic [9:0] PH     = 10'(PADDLE_H);
  localparam logic [9:0] L_FACE = 10'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [9:0] R_FACE = 10'(RIGHT_PADDLE_X);
  localparam logic [9:0] R_STOP = 10'(RIGHT_PADDLE_X - BALL_SIZE);
  localparam logic [9:0] X_LIM  = 10'(H_RES);

  localparam int               CNT_W    = $clog2(SERVE_DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVE_DELAY);

  state_t           state_q, state_d;
  logic             dx_q, dx_d;
  logic             dy_q, dy_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [9:0]       x_d, y_d;
  logic [1:0]       col_d, mis_d;

  logic [9:0]       y_next;
  logic             dy_next;
  logic             overlap_l, overlap_r;
  logic             hit_l, hit_r, miss_l, miss_r;

  // Evaluate the wall bounce and paddle/miss conditions from the current position.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    y_next  = ball_y;
    dy_next = dy_q;
    if (dy_q) begin
      if (ball_y + STEP >= Y_MAX) begin
        y_next  = Y_MAX;
        dy_next = 1'b0;
      end else begin
        y_next  = ball_y + STEP;
      end
    end else begin
      if (ball_y <= STEP) begin
        y_next  = '0;
        dy_next = 1'b1;
      end else begin
        y_next  = ball_y - STEP;
      end
    end

    // Overlap uses the pre-update y so the hit test matches the frame drawn.
    overlap_l = (ball_y + BSZ > paddle_l_y) && (ball_y < paddle_l_y + PH);
    overlap_r = (ball_y + BSZ > paddle_r_y) && (ball_y < paddle_r_y + PH);

    hit_l  = !dx_q && (ball_x >= L_FACE) && (ball_x - STEP <= L_FACE) && overlap_l;
    hit_r  =  dx_q && (ball_x + BSZ <= R_FACE) && (ball_x + STEP + BSZ >= R_FACE) && overlap_r;
    miss_l = !dx_q && !hit_l && (ball_x <= STEP);
    miss_r =  dx_q && !hit_r && (ball_x + STEP + BSZ >= X_LIM);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) state_q <= HOLD;
    else       state_q <= state_d;
  end

  // Next-state logic: restart dominates, otherwise transitions happen on the tick.
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = HOLD;
    end else if (endofframe) begin
      case (state_q)
        HOLD:     if (serve)              state_d = MOVING;
        MOVING:   if (miss_l || miss_r)   state_d = RECENTER;
        RECENTER: if (frame_cnt_q == '0)  state_d = MOVING;
        default:                          state_d = HOLD;
      endcase
    end
  end

  // Datapath next values: position, direction, serve counter and event pulses.
  always_comb begin
    x_d         = ball_x;
    y_d         = ball_y;
    dx_d        = dx_q;
    dy_d        = dy_q;
    frame_cnt_d = frame_cnt_q;
    col_d       = 2'b00;
    mis_d       = 2'b00;
    if (restart) begin
      x_d = CX;
      y_d = CY;
    end else if (endofframe) begin
      case (state_q)
        MOVING: begin
          if (hit_l) begin
            x_d      = L_FACE;
            dx_d     = 1'b1;
            y_d      = y_next;
            dy_d     = dy_next;
            col_d[0] = 1'b1;
          end else if (hit_r) begin
            x_d      = R_STOP;
            dx_d     = 1'b0;
            y_d      = y_next;
            dy_d     = dy_next;
            col_d[1] = 1'b1;
          end else if (miss_l || miss_r) begin
            // Serve restarts from centre heading toward the side that missed.
            x_d         = CX;
            y_d         = CY;
            dx_d        = miss_r;
            frame_cnt_d = CNT_LOAD;
            mis_d       = {miss_r, miss_l};
          end else begin
            x_d  = dx_q ? ball_x + STEP : ball_x - STEP;
            y_d  = y_next;
            dy_d = dy_next;
          end
        end
        RECENTER: begin
          if (frame_cnt_q != '0) frame_cnt_d = frame_cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers; isMoving follows the state register exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_x      <= CX;
      ball_y      <= CY;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      frame_cnt_q <= '0;
      collided    <= 2'b00;
      missed      <= 2'b00;
      isMoving    <= 1'b0;
    end else begin
      ball_x      <= x_d;
      ball_y      <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      frame_cnt_q <= frame_cnt_d;
      collided    <= col_d;
      missed      <= mis_d;
      isMoving    <= (state_d == MOVING);
    end
  end

endmodule
